// File: rtl/arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-cycle counter for the arbiter; expired goes high once TIMEOUT cycles
// have been counted since the last clear.
module arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-first.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_ack,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata
);

  arb_state_t        state;
  arb_state_t        next_state;
  owner_t            owner_q;
  owner_t            grant_d;
  logic              expired;
  logic              mem_we_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WIDTH-1:0]  mem_wdata_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              err_q;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= OWN_D;
    end else if ((state == IDLE) && (if_req || d_req)) begin
      last_grant <= grant_d;
    end
  end
`endif

  // Winner selection; only meaningful while IDLE sees a pending request.
  always_comb begin
    grant_d = OWN_IF;
    if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = (last_grant == OWN_D) ? OWN_IF : OWN_D;
`else
      grant_d = OWN_D;
`endif
    end else if (d_req) begin
      grant_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (if_req || d_req) next_state = ISSUE;
      ISSUE:   next_state = mem_ack ? RESP : WAIT;
      WAIT:    if (mem_ack || expired) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latching at grant and response capture; ack beats timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_q <= grant_d;
            err_q   <= 1'b0;
            if (grant_d == OWN_D) begin
              mem_we_q    <= d_we;
              mem_size_q  <= d_size;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_size_q  <= SZ_WORD;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        ISSUE, WAIT: begin
          if (mem_ack) begin
            rdata_q <= mem_we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if ((state == WAIT) && expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(expired)
  );

  assign mem_req   = (state == ISSUE) || (state == WAIT);
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = (state == RESP) && (owner_q == OWN_IF);
  assign d_ack     = (state == RESP) && (owner_q == OWN_D);
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset
// corner case and randomized transactions against a rule-level model.
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [15:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic model_last_d = 1'b1;

  typedef struct {
    logic        ifq;
    logic [15:0] ia;
    logic        dq;
    logic        we;
    logic [1:0]  sz;
    logic [15:0] da;
    logic [31:0] wd;
    int          w;
    logic [31:0] mdata;
    logic        keep;
    logic        exp_d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  mem_port_arbiter #(
    .WIDTH(32), .ADDR_W(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ifq, input logic [15:0] ia, input logic dq,
                              input logic we, input logic [1:0] sz, input logic [15:0] da,
                              input logic [31:0] wd, input int w, input logic [31:0] mdata,
                              input logic keep, input logic exp_d,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.ifq = ifq; v.ia = ia; v.dq = dq; v.we = we; v.sz = sz; v.da = da; v.wd = wd;
    v.w = w; v.mdata = mdata; v.keep = keep; v.exp_d = exp_d;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic int outputs_or();
    return int'(mem_req | if_ack | d_ack | err | mem_we | (|mem_size) | (|mem_addr) |
                (|mem_wdata) | (|if_rdata) | (|d_rdata));
  endfunction

  // Runs one transaction starting at a negedge in IDLE; the memory acks on
  // its w-th cycle after mem_req rises (w=0 acks in ISSUE, w<0 never acks).
  task automatic applyStimulus(input vec_t v);
    int          cyc = 0;
    int          reqcyc = 0;
    int          lat_exp;
    int          req_exp;
    bit          seen = 0;
    bit          fields_bad = 0;
    logic        got_if = 1'b0;
    logic        got_d = 1'b0;
    logic [31:0] got_rdata = '0;
    logic        got_err = 1'b0;
    if_req = v.ifq; if_addr = v.ia;
    d_req = v.dq; d_we = v.we; d_size = v.sz; d_addr = v.da; d_wdata = v.wd;
    mem_ack = 1'b0;
    if (v.w >= 0 && v.w <= TO + 1) begin
      lat_exp = 2 + v.w; req_exp = v.w + 1;
    end else begin
      lat_exp = TO + 3; req_exp = TO + 2;
    end
    while (!seen && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        reqcyc++;
        if (v.exp_d)
          fields_bad |= (mem_we !== v.we) || (mem_size !== v.sz) ||
                        (mem_addr !== v.da) || (mem_wdata !== v.wd);
        else
          fields_bad |= (mem_we !== 1'b0) || (mem_size !== 2'b10) || (mem_addr !== v.ia);
        if (reqcyc - 1 == v.w) begin
          mem_ack = 1'b1;
          mem_rdata = v.mdata;
        end
      end
      if (if_ack || d_ack) begin
        seen = 1;
        got_if = if_ack; got_d = d_ack; got_err = err;
        got_rdata = d_ack ? d_rdata : if_rdata;
      end
    end
    checkOutput("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("ack_latency", 32'(cyc), 32'(lat_exp));
      checkOutput("mem_req_cycles", 32'(reqcyc), 32'(req_exp));
      checkOutput("ack_owner", {30'd0, got_if, got_d}, v.exp_d ? 32'd1 : 32'd2);
      checkOutput("rdata", got_rdata, v.exp_rdata);
      checkOutput("err", 32'(got_err), 32'(v.exp_err));
      checkOutput("mem_fields_bad", 32'(fields_bad), 32'd0);
    end
    if (!v.keep) begin
      if_req = 1'b0;
      d_req = 1'b0;
    end
    model_last_d = v.exp_d;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_bubble", {29'd0, mem_req, if_ack, d_ack}, 32'd0);
  endtask

  initial begin
    int   nfail;
    vec_t v;
    int   pick;
    int   r;

    vecs.push_back(mk(1, 16'h0010, 0, 0, 2'b00, 16'h0000, 32'h0, 0, 32'h00500093, 0, 0, 32'h00500093, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 2'b10, 16'h0100, 32'hDEADBEEF, 4, 32'h12345678, 0, 1, 32'h0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 2'b01, 16'h0202, 32'h0, 1, 32'h0000BEEF, 0, 1, 32'h0000BEEF, 0));
    vecs.push_back(mk(1, 16'h0044, 0, 0, 2'b00, 16'h0000, 32'h0, -1, 32'h99999999, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 2'b00, 16'h0301, 32'h0, 2, 32'h000000A5, 0, 1, 32'h000000A5, 0));
    vecs.push_back(mk(1, 16'h0080, 0, 0, 2'b00, 16'h0000, 32'h0, TO + 1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 16'h0084, 0, 0, 2'b00, 16'h0000, 32'h0, TO, 32'h11112222, 0, 0, 32'h11112222, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 2'b00, 16'h0500, 32'h0BADF00D, -1, 32'h77777777, 0, 1, 32'h0, 1));
    vecs.push_back(mk(1, 16'h0088, 0, 0, 2'b00, 16'h0000, 32'h0, 0, 32'h13572468, 0, 0, 32'h13572468, 0));
`ifdef ARB_ROUND_ROBIN_EN
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 0, 32'h0A000000, 1, 1, 32'h0A000000, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 1, 32'h0A000001, 1, 0, 32'h0A000001, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 0, 32'h0A000002, 1, 1, 32'h0A000002, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 1, 32'h0A000003, 0, 0, 32'h0A000003, 0));
`else
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 0, 32'h0A000000, 1, 1, 32'h0A000000, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 1, 32'h0A000001, 1, 1, 32'h0A000001, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 0, 32'h0A000002, 1, 1, 32'h0A000002, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 0, 2'b10, 16'h0400, 32'h0, 1, 32'h0A000003, 0, 1, 32'h0A000003, 0));
`endif

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'(outputs_or()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", 32'(outputs_or()), 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // mem_ack while idle must not produce any response
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF0000;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_mem_ack", {29'd0, mem_req, if_ack, d_ack}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stray_mem_ack_after", {29'd0, mem_req, if_ack, d_ack}, 32'd0);

    // Reset in the middle of WAIT aborts silently
    if_req = 1'b1;
    if_addr = 16'h0090;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("wait_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_wait", 32'(outputs_or()), 32'd0);
    nfail = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_ack || d_ack || mem_req) nfail++;
    end
    checkOutput("no_ack_in_reset", 32'(nfail), 32'd0);
    rst = 1'b1;
    model_last_d = 1'b1;
    applyStimulus(mk(1, 16'h0090, 0, 0, 2'b00, 16'h0000, 32'h0, 0, 32'h24681357, 0, 0, 32'h24681357, 0));

    // Randomized traffic against the rule-level model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      v.ifq = r[0];
      v.dq = r[1];
      v.ia = 16'($urandom);
      v.we = 1'($urandom_range(0, 1));
      v.sz = 2'($urandom_range(0, 2));
      v.da = 16'($urandom);
      v.wd = $urandom;
      pick = $urandom_range(0, 9);
      if (pick <= 6) v.w = pick;
      else if (pick == 7) v.w = -1;
      else if (pick == 8) v.w = TO;
      else v.w = TO + 1;
      v.mdata = $urandom;
      v.keep = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      v.exp_d = v.dq && (!v.ifq || !model_last_d);
`else
      v.exp_d = v.dq;
`endif
      v.exp_err = (v.w < 0);
      if (v.exp_err || (v.exp_d && v.we)) v.exp_rdata = 32'h0;
      else v.exp_rdata = v.mdata;
      applyStimulus(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
